// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared types and constants for the background fetch path.
//                Holds the fetch-phase enumeration, VRAM base addresses, the
//                dot numbers that frame the fetch and scroll-strobe windows,
//                and small helpers for walking the phase sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

  // One 8-dot tile fetch. The numeric values equal (dot-1) mod 8 so the
  // phase derived from the dot counter can be cast straight into this type.
  typedef enum logic [3:0] {
    NT_ADDR = 4'd0,
    NT_DATA = 4'd1,
    AT_ADDR = 4'd2,
    AT_DATA = 4'd3,
    PL_ADDR = 4'd4,
    PL_DATA = 4'd5,
    PH_ADDR = 4'd6,
    PH_DATA = 4'd7,
    IDLE    = 4'd8
  } fetch_phase_t;

  localparam logic [13:0] NT_BASE            = 14'h2000;
  localparam logic [13:0] AT_BASE            = 14'h23C0;

  localparam logic [8:0]  DOT_FETCH_END      = 9'd256;
  localparam logic [8:0]  DOT_PREFETCH_START = 9'd321;
  localparam logic [8:0]  DOT_PREFETCH_END   = 9'd336;
  localparam logic [8:0]  DOT_HCOPY          = 9'd257;
  localparam logic [8:0]  VCOPY_START        = 9'd280;
  localparam logic [8:0]  VCOPY_END          = 9'd304;
  localparam logic [8:0]  DOT_DUMMY_A        = 9'd337;
  localparam logic [8:0]  DOT_DUMMY_B        = 9'd339;

  function automatic fetch_phase_t next_phase(input fetch_phase_t p);
    case (p)
      NT_ADDR: return NT_DATA;
      NT_DATA: return AT_ADDR;
      AT_ADDR: return AT_DATA;
      AT_DATA: return PL_ADDR;
      PL_ADDR: return PL_DATA;
      PL_DATA: return PH_ADDR;
      PH_ADDR: return PH_DATA;
      PH_DATA: return NT_ADDR;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic is_addr_phase(input fetch_phase_t p);
    return (p == NT_ADDR) || (p == AT_ADDR) || (p == PL_ADDR) || (p == PH_ADDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bg_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bg_addr_gen
//  Description : Combinational VRAM address mux for the background fetch.
//                Selects the nametable, attribute, or pattern-plane address
//                for the given phase. Data phases and IDLE yield zero.
//  Ports       : phase_i       - fetch phase being executed
//                v_addr_i      - loopy v (fineY, NT, coarseY, coarseX)
//                nt_byte_i     - tile index latched from the nametable
//                pattern_sel_i - background pattern table select
//                addr_o        - 14-bit VRAM address
//  Revision    : 1.0 - initial release
// ============================================================================
module bg_addr_gen
  import ppu_pkg::*;
(
  input  fetch_phase_t phase_i,
  input  logic [14:0]  v_addr_i,
  input  logic [7:0]   nt_byte_i,
  input  logic         pattern_sel_i,
  output logic [13:0]  addr_o
);

  always_comb begin
    addr_o = '0;
    case (phase_i)
      NT_ADDR: addr_o = NT_BASE | {2'b00, v_addr_i[11:0]};
      // Attribute byte covers a 4x4 tile block: nametable select, then
      // coarseY/4 in bits 5:3 and coarseX/4 in bits 2:0.
      AT_ADDR: addr_o = AT_BASE | {2'b00, v_addr_i[11:10], 4'b0000,
                                   v_addr_i[9:7], v_addr_i[4:2]};
      // Pattern planes: 16 bytes per tile, fine Y selects the row, bit 3
      // picks the high plane.
      PL_ADDR: addr_o = {1'b0, pattern_sel_i, nt_byte_i, 1'b0, v_addr_i[14:12]};
      PH_ADDR: addr_o = {1'b0, pattern_sel_i, nt_byte_i, 1'b1, v_addr_i[14:12]};
      default: addr_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/background_tile_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : background_tile_fetcher
//  Description : Sequences the 8-dot background fetch (NT, AT, PL, PH),
//                drives VRAM address/read, hands completed tiles to the
//                pixel shifter with a load pulse, and issues the scroll
//                increment/copy strobes. All outputs are registered.
//  Ports       : clock, reset     - clock, synchronous active-high reset
//                clock_EN         - dot enable; state advances only when high
//                rendering_EN     - rendering enabled
//                dot, scanline    - raster position from the timing block
//                vAddr            - current loopy v
//                patternSel       - background pattern table select
//                vramData         - VRAM read data
//                vramAddr/vramRead- VRAM address and read strobe
//                tileLowByte/tileHighByte/tileAttr - next tile to shifter
//                loadIn           - shifter load pulse
//                incHorizontal/incVertical/copyHorizontal/copyVertical
//                                 - scroll register strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module background_tile_fetcher
  import ppu_pkg::*;
#(
  parameter int PRERENDER_LINE    = 261,
  parameter int LAST_VISIBLE_LINE = 239
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_EN,
  input  logic        rendering_EN,
  input  logic [8:0]  dot,
  input  logic [8:0]  scanline,
  input  logic [14:0] vAddr,
  input  logic        patternSel,
  input  logic [7:0]  vramData,
  output logic [13:0] vramAddr,
  output logic        vramRead,
  output logic [7:0]  tileLowByte,
  output logic [7:0]  tileHighByte,
  output logic [1:0]  tileAttr,
  output logic        loadIn,
  output logic        incHorizontal,
  output logic        incVertical,
  output logic        copyHorizontal,
  output logic        copyVertical
);

  // --------------------------------------------------------------------------
  // Raster decode
  // --------------------------------------------------------------------------
  logic         active_line;
  logic         render_line;
  logic         fetch_window;
  logic         dummy_fetch;
  logic         load_window;
  logic [2:0]   phase;
  fetch_phase_t phase_now;

  assign active_line = (scanline <= 9'(LAST_VISIBLE_LINE)) ||
                       (scanline == 9'(PRERENDER_LINE));
  assign render_line = active_line && rendering_EN;

  assign fetch_window = render_line &&
                        (((dot >= 9'd1) && (dot <= DOT_FETCH_END)) ||
                         ((dot >= DOT_PREFETCH_START) && (dot <= DOT_PREFETCH_END)));

  // (dot-1) mod 8 only depends on the low three bits of dot.
  assign phase     = dot[2:0] - 3'd1;
  assign phase_now = fetch_phase_t'({1'b0, phase});

  assign dummy_fetch = render_line && ((dot == DOT_DUMMY_A) || (dot == DOT_DUMMY_B));

  // Loads land one dot after each tile completes, including the dot just
  // past the end of each fetch run (257 and 337).
  assign load_window = ((dot >= 9'd9)   && (dot <= DOT_HCOPY)) ||
                       ((dot >= 9'd329) && (dot <= DOT_DUMMY_A));

  // --------------------------------------------------------------------------
  // Phase tracking. A tile only starts at an NT_ADDR-aligned dot, and a
  // running tile only continues while the dot keeps stepping in sequence.
  // After reset or a rendering drop we therefore sit in IDLE until the next
  // tile boundary and never transfer a half-fetched tile.
  // --------------------------------------------------------------------------
  fetch_phase_t phase_q, phase_d;

  always_comb begin
    phase_d = IDLE;
    if (fetch_window &&
        ((phase == 3'd0) || ((phase_q != IDLE) && (next_phase(phase_q) == phase_now)))) begin
      phase_d = phase_now;
    end
  end

  // --------------------------------------------------------------------------
  // Address generation
  // --------------------------------------------------------------------------
  logic [7:0]   nt_byte_q, nt_byte_d;
  fetch_phase_t gen_phase;
  logic [13:0]  gen_addr;

  assign gen_phase = dummy_fetch ? NT_ADDR : phase_d;

  bg_addr_gen u_addr_gen (
    .phase_i       (gen_phase),
    .v_addr_i      (vAddr),
    .nt_byte_i     (nt_byte_q),
    .pattern_sel_i (patternSel),
    .addr_o        (gen_addr)
  );

  // Attribute quadrant: shift of {coarseY[1], coarseX[1], 0} expressed as a
  // 2-bit field select.
  logic [1:0] attr_sel;
  always_comb begin
    case ({vAddr[6], vAddr[1]})
      2'b00:   attr_sel = vramData[1:0];
      2'b01:   attr_sel = vramData[3:2];
      2'b10:   attr_sel = vramData[5:4];
      default: attr_sel = vramData[7:6];
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [13:0] vram_addr_q, vram_addr_d;
  logic        vram_read_q, vram_read_d;
  logic [1:0]  attr_bits_q, attr_bits_d;
  logic [7:0]  pend_low_q,  pend_low_d;
  logic [7:0]  tile_low_q,  tile_low_d;
  logic [7:0]  tile_high_q, tile_high_d;
  logic [1:0]  tile_attr_q, tile_attr_d;
  logic        load_q, load_d;
  logic        inc_h_q, inc_h_d;
  logic        inc_v_q, inc_v_d;
  logic        copy_h_q, copy_h_d;
  logic        copy_v_q, copy_v_d;

  always_comb begin
    vram_addr_d = vram_addr_q;
    vram_read_d = 1'b0;
    nt_byte_d   = nt_byte_q;
    attr_bits_d = attr_bits_q;
    pend_low_d  = pend_low_q;
    tile_low_d  = tile_low_q;
    tile_high_d = tile_high_q;
    tile_attr_d = tile_attr_q;

    if (!rendering_EN) begin
      vram_addr_d = '0;
    end else if (dummy_fetch || is_addr_phase(phase_d)) begin
      vram_addr_d = gen_addr;
      vram_read_d = 1'b1;
    end

    case (phase_d)
      NT_DATA: nt_byte_d   = vramData;
      AT_DATA: attr_bits_d = attr_sel;
      PL_DATA: pend_low_d  = vramData;
      // High plane goes straight to the output together with the pending
      // low plane and attribute, so no separate high-plane holding register.
      PH_DATA: begin
        tile_low_d  = pend_low_q;
        tile_high_d = vramData;
        tile_attr_d = attr_bits_q;
      end
      default: ;
    endcase

    load_d   = render_line && (phase == 3'd0) && load_window;
    inc_h_d  = fetch_window && (phase == 3'd7);
    inc_v_d  = render_line && (dot == DOT_FETCH_END);
    copy_h_d = render_line && (dot == DOT_HCOPY);
    copy_v_d = render_line && (scanline == 9'(PRERENDER_LINE)) &&
               (dot >= VCOPY_START) && (dot <= VCOPY_END);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= IDLE;
      vram_addr_q <= '0;
      vram_read_q <= 1'b0;
      nt_byte_q   <= '0;
      attr_bits_q <= '0;
      pend_low_q  <= '0;
      tile_low_q  <= '0;
      tile_high_q <= '0;
      tile_attr_q <= '0;
      load_q      <= 1'b0;
      inc_h_q     <= 1'b0;
      inc_v_q     <= 1'b0;
      copy_h_q    <= 1'b0;
      copy_v_q    <= 1'b0;
    end else if (clock_EN) begin
      phase_q     <= phase_d;
      vram_addr_q <= vram_addr_d;
      vram_read_q <= vram_read_d;
      nt_byte_q   <= nt_byte_d;
      attr_bits_q <= attr_bits_d;
      pend_low_q  <= pend_low_d;
      tile_low_q  <= tile_low_d;
      tile_high_q <= tile_high_d;
      tile_attr_q <= tile_attr_d;
      load_q      <= load_d;
      inc_h_q     <= inc_h_d;
      inc_v_q     <= inc_v_d;
      copy_h_q    <= copy_h_d;
      copy_v_q    <= copy_v_d;
    end
  end

  assign vramAddr       = vram_addr_q;
  assign vramRead       = vram_read_q;
  assign tileLowByte    = tile_low_q;
  assign tileHighByte   = tile_high_q;
  assign tileAttr       = tile_attr_q;
  assign loadIn         = load_q;
  assign incHorizontal  = inc_h_q;
  assign incVertical    = inc_v_q;
  assign copyHorizontal = copy_h_q;
  assign copyVertical   = copy_v_q;

endmodule
`default_nettype wire
